// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: issues sequential or redirected fetches over a req/ack
// memory port and buffers {PC, instruction} pairs in a DEPTH-entry FIFO for decode.
module if_prefetch_stage #(
  parameter int                  WORD_LEN     = 32,
  parameter int                  DEPTH        = 4,
  parameter logic [WORD_LEN-1:0] RESET_PC     = '0,
  parameter int                  INSTR_BYTES  = 4,
  parameter int                  OFFSET_SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    brTaken,
  input  logic [WORD_LEN-1:0]     brPC,
  input  logic [WORD_LEN-1:0]     brOffset,
  input  logic                    freeze,
  output logic                    imemReq,
  output logic [WORD_LEN-1:0]     imemAddr,
  input  logic                    imemAck,
  input  logic [WORD_LEN-1:0]     imemData,
  output logic                    outValid,
  output logic [WORD_LEN-1:0]     outPC,
  output logic [WORD_LEN-1:0]     outInstr,
  output logic [$clog2(DEPTH):0]  fifoCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t              state, state_nxt;
  logic [WORD_LEN-1:0] fetch_pc, fetch_pc_nxt;
  logic                req_nxt;
  logic [WORD_LEN-1:0] addr_nxt;
  logic [WORD_LEN-1:0] pc_mem    [DEPTH];
  logic [WORD_LEN-1:0] instr_mem [DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count, count_nxt;
  logic                push, pop, space;
  logic [WORD_LEN-1:0] target, seq_pc;

  assign target = brPC + (brOffset << OFFSET_SHIFT);
  assign seq_pc = fetch_pc + WORD_LEN'(INSTR_BYTES);

  // A redirect empties the FIFO outright, overriding any push or pop this cycle.
  assign push      = (state == REQ) && imemAck && !brTaken;
  assign pop       = outValid && !freeze;
  assign count_nxt = brTaken ? '0 : (count + CW'(push) - CW'(pop));
  assign space     = (count_nxt < CW'(DEPTH));

  assign outValid  = (count != '0);
  assign outPC     = outValid ? pc_mem[rd_ptr] : '0;
  assign outInstr  = outValid ? instr_mem[rd_ptr] : '0;
  assign fifoCount = count;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_nxt      = imemReq;
    addr_nxt     = imemAddr;
    case (state)
      IDLE: begin
        if (brTaken) begin
          fetch_pc_nxt = target;
        end else if (space) begin
          req_nxt   = 1'b1;
          addr_nxt  = fetch_pc;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (imemAck) begin
          if (brTaken) begin
            fetch_pc_nxt = target;
            addr_nxt     = target;
            req_nxt      = 1'b1;
          end else begin
            fetch_pc_nxt = seq_pc;
            if (space) begin
              req_nxt  = 1'b1;
              addr_nxt = seq_pc;
            end else begin
              req_nxt   = 1'b0;
              state_nxt = IDLE;
            end
          end
        end else if (brTaken) begin
          // The response for the old address must still be absorbed, so hold the bus.
          fetch_pc_nxt = target;
          state_nxt    = DROP;
        end
      end
      DROP: begin
        if (brTaken) fetch_pc_nxt = target;
        if (imemAck) begin
          req_nxt   = 1'b1;
          addr_nxt  = brTaken ? target : fetch_pc;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      imemReq  <= 1'b0;
      imemAddr <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      imemReq  <= req_nxt;
      imemAddr <= addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || brTaken) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= imemAddr;
      instr_mem[wr_ptr] <= imemData;
    end
  end

  // Issue is gated on free space, so a push can never land on a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && (count == CW'(DEPTH))));
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed scenarios plus randomized traffic checked
// against an instruction-stream model (sequential PCs restarted at each branch target).
module tb_if_prefetch_stage;

  localparam logic [31:0] MAGIC   = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst, brTaken, freeze, imemReq, imemAck, outValid;
  logic [31:0] brPC, brOffset, imemAddr, imemData, outPC, outInstr;
  logic [2:0]  fifoCount;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_instr;
  logic [2:0]  w_cnt;

  int          total = 0;
  int          bad = 0;
  int          pops = 0;
  int          mem_lat = 0;
  int          mem_wait = 0;
  bit          mem_auto = 1'b1;
  logic [31:0] exp_pc, w_exp, hold_addr;
  logic        flush_chk, hold_chk;

  always #5 clk = ~clk;

  if_prefetch_stage dut (
    .clk(clk), .rst(rst), .brTaken(brTaken), .brPC(brPC), .brOffset(brOffset),
    .freeze(freeze), .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck),
    .imemData(imemData), .outValid(outValid), .outPC(outPC), .outInstr(outInstr),
    .fifoCount(fifoCount)
  );

  // Second instance starting near the top of the address space, zero-wait memory.
  if_prefetch_stage #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst(rst), .brTaken(1'b0), .brPC(32'h0), .brOffset(32'h0),
    .freeze(1'b0), .imemReq(w_req), .imemAddr(w_addr), .imemAck(w_req),
    .imemData(w_addr ^ MAGIC), .outValid(w_valid), .outPC(w_pc), .outInstr(w_instr),
    .fifoCount(w_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic int pickLat();
    return (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
  endfunction

  // Stream model: every consumed entry must be the next sequential PC.
  task automatic observe();
    flush_chk = 1'b0;
    hold_chk  = 1'b0;
    if (rst) begin
      exp_pc = 32'h0;
      w_exp  = WRAP_PC;
    end else begin
      if (outValid && !freeze && !brTaken) begin
        checkOutput("pop_pc", outPC, exp_pc);
        checkOutput("pop_instr", outInstr, exp_pc ^ MAGIC);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (brTaken) begin
        exp_pc    = brPC + brOffset * 32'd4;
        flush_chk = 1'b1;
      end
      hold_chk  = imemReq && !imemAck;
      hold_addr = imemAddr;
      if (w_valid) begin
        checkOutput("wrap_pc", w_pc, w_exp);
        checkOutput("wrap_instr", w_instr, w_exp ^ MAGIC);
        checkOutput("wrap_cnt_max", 32'(w_cnt > 3'd4), 32'd0);
        w_exp = w_exp + 32'd4;
      end
    end
  endtask

  task automatic afterEdge();
    if (flush_chk) begin
      checkOutput("flush_valid", outValid, 32'd0);
      checkOutput("flush_cnt", fifoCount, 32'd0);
    end
    if (hold_chk) begin
      checkOutput("hold_req", imemReq, 32'd1);
      checkOutput("hold_addr", imemAddr, hold_addr);
    end
  endtask

  task automatic memStep();
    if (mem_auto) begin
      if (imemReq && mem_wait == 0) begin
        imemAck  = 1'b1;
        imemData = imemAddr ^ MAGIC;
        mem_wait = pickLat();
      end else begin
        imemAck  = 1'b0;
        imemData = $urandom;
        if (imemReq) mem_wait--;
        else mem_wait = pickLat();
      end
    end
  endtask

  task automatic tick();
    observe();
    @(posedge clk);
    #1;
    afterEdge();
    memStep();
  endtask

  task automatic applyStimulus(input logic tk, input logic [31:0] pc, input logic [31:0] off,
                               input logic frz);
    brTaken  = tk;
    brPC     = pc;
    brOffset = off;
    freeze   = frz;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("rst_req", imemReq, 32'd0);
    checkOutput("rst_addr", imemAddr, 32'd0);
    checkOutput("rst_valid", outValid, 32'd0);
    checkOutput("rst_pc", outPC, 32'd0);
    checkOutput("rst_instr", outInstr, 32'd0);
    checkOutput("rst_cnt", fifoCount, 32'd0);
    checkOutput("rst_wvalid", w_valid, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found, acked;
    rst = 1'b1; imemAck = 1'b0; imemData = 32'h0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    exp_pc = 32'h0; w_exp = WRAP_PC; flush_chk = 1'b0; hold_chk = 1'b0; hold_addr = 32'h0;

    $display("[TB] zero-wait sequential fetch");
    mem_lat = 0;
    applyReset();
    tick();
    checkOutput("p1_req", imemReq, 32'd1);
    checkOutput("p1_addr0", imemAddr, 32'h0);
    checkOutput("p1_valid0", outValid, 32'd0);
    tick();
    checkOutput("p1_addr4", imemAddr, 32'h4);
    checkOutput("p1_valid1", outValid, 32'd1);
    checkOutput("p1_pc0", outPC, 32'h0);
    checkOutput("p1_instr0", outInstr, MAGIC);
    tick();
    checkOutput("p1_addr8", imemAddr, 32'h8);
    checkOutput("p1_pc4", outPC, 32'h4);
    tick();
    checkOutput("p1_pc8", outPC, 32'h8);
    checkOutput("p1_instr8", outInstr, 32'h8 ^ MAGIC);
    checkOutput("p1_wrap_zero", w_pc, 32'h0);

    $display("[TB] freeze fills the FIFO");
    applyReset();
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("p2_cnt_full", fifoCount, 32'd4);
    checkOutput("p2_req_off", imemReq, 32'd0);
    checkOutput("p2_head", outPC, 32'h0);
    freeze = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("p2_seq_valid", outValid, 32'd1);
      checkOutput("p2_seq_pc", outPC, 32'(k * 4));
      tick();
    end

    $display("[TB] branch while a slow request is outstanding");
    mem_lat = 3;
    applyReset();
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (imemReq && imemAddr == 32'h10 && !imemAck) found = 1'b1;
      else tick();
    end
    checkOutput("p3_found", found, 32'd1);
    applyStimulus(1'b1, 32'h20, 32'd3, 1'b0);
    tick();
    brTaken = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 10 && !acked; i++) begin
      checkOutput("p3_hold", imemAddr, 32'h10);
      if (imemAck) acked = 1'b1;
      tick();
    end
    checkOutput("p3_acked", acked, 32'd1);
    checkOutput("p3_req", imemReq, 32'd1);
    checkOutput("p3_redirect", imemAddr, 32'h2C);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (outValid) found = 1'b1;
      else tick();
    end
    checkOutput("p3_got_valid", found, 32'd1);
    checkOutput("p3_first_pc", outPC, 32'h2C);
    checkOutput("p3_first_instr", outInstr, 32'h2C ^ MAGIC);

    $display("[TB] branch coinciding with ack and pop");
    mem_lat = 0;
    applyReset();
    for (int i = 0; i < 5; i++) tick();
    checkOutput("p4_pre_valid", outValid, 32'd1);
    applyStimulus(1'b1, 32'h100, 32'hFFFF_FFFE, 1'b0);
    tick();
    brTaken = 1'b0;
    checkOutput("p4_valid0", outValid, 32'd0);
    checkOutput("p4_cnt0", fifoCount, 32'd0);
    checkOutput("p4_req", imemReq, 32'd1);
    checkOutput("p4_addr", imemAddr, 32'hF8);
    tick();
    checkOutput("p4_valid1", outValid, 32'd1);
    checkOutput("p4_pc", outPC, 32'hF8);
    checkOutput("p4_instr", outInstr, 32'hF8 ^ MAGIC);

    $display("[TB] reset while discarding a stale response");
    mem_lat = 3;
    applyReset();
    tick();
    checkOutput("p5_req", imemReq, 32'd1);
    applyStimulus(1'b1, 32'h40, 32'd1, 1'b0);
    tick();
    brTaken = 1'b0;
    mem_auto = 1'b0;
    imemAck = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("p5_rst_req", imemReq, 32'd0);
    checkOutput("p5_rst_addr", imemAddr, 32'd0);
    checkOutput("p5_rst_valid", outValid, 32'd0);
    checkOutput("p5_rst_pc", outPC, 32'd0);
    checkOutput("p5_rst_instr", outInstr, 32'd0);
    checkOutput("p5_rst_cnt", fifoCount, 32'd0);
    rst = 1'b0;
    imemAck = 1'b1;
    imemData = 32'hDEAD_BEEF;
    tick();
    checkOutput("p5_late_cnt", fifoCount, 32'd0);
    checkOutput("p5_restart_req", imemReq, 32'd1);
    checkOutput("p5_restart_addr", imemAddr, 32'h0);
    imemAck = 1'b0;
    mem_wait = mem_lat;
    mem_auto = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (outValid) found = 1'b1;
      else tick();
    end
    checkOutput("p5_got_valid", found, 32'd1);
    checkOutput("p5_first_pc", outPC, 32'h0);
    checkOutput("p5_first_instr", outInstr, MAGIC);

    $display("[TB] randomized traffic");
    mem_lat = -1;
    applyReset();
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 24) == 0, $urandom & 32'hFFFF_FFFC,
                    32'($urandom_range(0, 64)) - 32'd32, $urandom_range(0, 3) == 0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("p6_progress", 32'(pops > 300), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
- Parametrised instruction-fetch stage that replaces the single-PC fetch path.
- Generates sequential and branch-redirected fetch addresses, talks to instruction memory over a variable-latency req/ack handshake, and buffers fetched {PC, instruction} pairs in a DEPTH-entry FIFO.
- Presents the FIFO head to the ID stage with valid/freeze flow control.
- A taken branch flushes the FIFO and discards any in-flight memory response.

Parameters:
- WORD_LEN, 32, width of PC, instruction and offset.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- RESET_PC, 0, fetch address after reset.
- INSTR_BYTES, 4, sequential PC increment.
- OFFSET_SHIFT, 2, left shift applied to brOffset.

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- brTaken, input, 1, redirect request, one cycle.
- brPC, input, WORD_LEN, PC of the branching instruction.
- brOffset, input, WORD_LEN, signed word offset.
- freeze, input, 1, downstream stall; head is not consumed while high.
- imemReq, output, 1, memory request, registered.
- imemAddr, output, WORD_LEN, request address, registered.
- imemAck, input, 1, response valid; may rise in the same cycle imemReq is high.
- imemData, input, WORD_LEN, instruction, valid with imemAck.
- outValid, output, 1, FIFO head valid.
- outPC, output, WORD_LEN, address of head instruction.
- outInstr, output, WORD_LEN, head instruction.
- fifoCount, output, log2(DEPTH)+1, occupancy.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: fetchPC=RESET_PC, state=IDLE, FIFO empty, imemReq=0, imemAddr=0, outValid=0, outPC=0, outInstr=0, fifoCount=0. Reset mid-transaction abandons the outstanding request; an imemAck arriving during or after reset with no request pending is ignored.
- Target arithmetic: target = brPC + (brOffset << OFFSET_SHIFT), truncated modulo 2^WORD_LEN. Sequential next = fetchPC + INSTR_BYTES, wraps at 2^WORD_LEN.
- Pop: occurs when outValid && !freeze. Output fields are the FIFO head, driven combinationally from storage.
- Push: occurs on imemAck in state REQ with no brTaken in the same cycle. It writes {imemAddr, imemData}.
- Occupancy: push and pop in the same cycle leave fifoCount unchanged. A push into a full FIFO is impossible by construction; assert in simulation.
- Issue rule: a request is registered for the next cycle only if (fifoCount after this edge) + (1 if request still outstanding) < DEPTH. At most one request is outstanding.
- State IDLE (no outstanding request):
  - If brTaken: flush FIFO, fetchPC=target, stay IDLE; issue is evaluated next cycle.
  - Else if space: imemReq=1, imemAddr=fetchPC, go REQ.
- State REQ (imemReq held high, imemAddr stable until ack):
  - ack && !brTaken: push, fetchPC=next. If space remains after the push, issue next immediately (imemReq stays 1, imemAddr=next). Otherwise imemReq=0 and go IDLE.
  - ack && brTaken: discard data, flush, fetchPC=target. Issue target next cycle if space (always, FIFO now empty), staying in REQ.
  - !ack && brTaken: flush, fetchPC=target, go DROP. imemReq and imemAddr are held.
- State DROP (waiting to discard a stale response; imemReq held, imemAddr unchanged):
  - brTaken: fetchPC=new target, stay DROP or leave on ack.
  - ack: discard, issue imemAddr=fetchPC, go REQ.
- Priority: brTaken flush beats pop and push in the same cycle, so outValid=0 the next cycle.
- Throughput: with a zero-wait ack (ack in every req cycle), one instruction enters per cycle. First outValid is 2 cycles after rst deassert.
- freeze: stalls only the consumer. Prefetch continues until the FIFO is full.

Test Plan:
- Reset then zero-wait memory (imemData=addr^32'hA5A5_0000), freeze=0 -> imemAddr 0,4,8,... on consecutive cycles. outValid first high 2 cycles after reset; outPC sequence 0,4,8 with matching outInstr.
- freeze=1 held, zero-wait memory -> fifoCount saturates at DEPTH=4 with outPC=0 at head, imemReq=0. Release freeze -> outPC 0,4,8,12,16 with no gap or duplicate.
- Memory with 3-cycle ack latency, brTaken at brPC=0x20, brOffset=3 while a request for 0x10 is outstanding -> imemAddr stays 0x10 until ack, the 0x10 data is never output, next imemAddr=0x2C, first valid outPC=0x2C.
- brTaken same cycle as ack and pop, brOffset=-2 (0xFFFFFFFE), brPC=0x100 -> FIFO flushed (outValid=0 next cycle), next imemAddr=0xF8, returned data discarded.
- Wrap: RESET_PC=0xFFFFFFF8, zero-wait memory -> outPC 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- rst asserted in DROP with ack arriving the next cycle -> all outputs at reset values, late ack ignored, fetch restarts at RESET_PC.
